// File: rtl/sipo_deserializer_if.sv
// Serial bit stream in, assembled word out with valid/ready, plus busy/overrun status.
// master drives the bit stream and ready; slave is the deserializer.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             d;
  logic             d_en;
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             overrun;

  modport master (
    output d, d_en, start, ready,
    input  data_out, valid, busy, overrun
  );

  modport slave (
    input  d, d_en, start, ready,
    output data_out, valid, busy, overrun
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Deserializer: frames of WIDTH bits from a strobed serial stream, word visible the cycle after its last bit.
// One-entry output register; a word completing while the held word is unconsumed is dropped with an overrun pulse.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  sipo_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] shifted_msb;
  logic [WIDTH-1:0] shifted_lsb;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_base;
  logic             valid_q;
  logic             overrun_q;
  logic             sample;
  logic             complete;

  // start discards any partial frame, so the bit sampled with it is always bit 0
  always_comb begin
    sr_base     = bus.start ? '0 : sr;
    cnt_base    = bus.start ? '0 : cnt;
    shifted_msb = {sr_base[WIDTH-2:0], bus.d};
    shifted_lsb = {bus.d, sr_base[WIDTH-1:1]};
    shifted     = MSB_FIRST ? shifted_msb : shifted_lsb;
    sample      = bus.d_en && (bus.start || (state == SHIFT));
    complete    = sample && (cnt_base == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
      if (bus.start) begin
        state <= SHIFT;
        sr    <= '0;
        cnt   <= '0;
      end
      if (sample) begin
        sr  <= shifted;
        cnt <= cnt_base + CW'(1);
      end
      if (complete) begin
        state <= IDLE;
        cnt   <= '0;
        // a consume on the same edge frees the register for the new word
        if (!valid_q || bus.ready) begin
          data_q  <= shifted;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state == SHIFT);
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus; a word scoreboard per instance.
module tb_sipo_deserializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  logic d;
  logic d_en;
  logic start;
  logic ready;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] q_msb[$];
  logic [W-1:0] q_lsb[$];
  logic [W-1:0] held_msb;
  logic [W-1:0] held_lsb;

  sipo_deserializer_if #(.WIDTH(W)) bm ();
  sipo_deserializer_if #(.WIDTH(W)) bl ();

  assign bm.d     = d;
  assign bm.d_en  = d_en;
  assign bm.start = start;
  assign bm.ready = ready;
  assign bl.d     = d;
  assign bl.d_en  = d_en;
  assign bl.start = start;
  assign bl.ready = ready;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bm)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bl)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rev8(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_data_m"}, 32'(bm.data_out), 32'h0);
    chk({tag, "_data_l"}, 32'(bl.data_out), 32'h0);
    chk({tag, "_valid"}, 32'({bm.valid, bl.valid}), 32'h0);
    chk({tag, "_busy"}, 32'({bm.busy, bl.busy}), 32'h0);
    chk({tag, "_ovr"}, 32'({bm.overrun, bl.overrun}), 32'h0);
  endtask

  // Completion check shared by full-speed and gapped frames.
  task automatic chk_done(input string tag, input bit drop);
    logic [W-1:0] em, el;
    if (drop) begin
      em = held_msb;
      el = held_lsb;
    end else begin
      em = q_msb.pop_front();
      el = q_lsb.pop_front();
      held_msb = em;
      held_lsb = el;
    end
    chk({tag, "_data_m"}, 32'(bm.data_out), 32'(em));
    chk({tag, "_data_l"}, 32'(bl.data_out), 32'(el));
    chk({tag, "_valid"}, 32'({bm.valid, bl.valid}), 32'h3);
    chk({tag, "_busy"}, 32'({bm.busy, bl.busy}), 32'h0);
    chk({tag, "_ovr"}, 32'({bm.overrun, bl.overrun}), drop ? 32'h3 : 32'h0);
  endtask

  // bits[W-1] is sent first, together with start; d_en held high throughout.
  task automatic send_frame(input string tag, input logic [W-1:0] bits,
                            input bit drop, input bit ready_last);
    if (!drop) begin
      q_msb.push_back(bits);
      q_lsb.push_back(rev8(bits));
    end
    for (int i = W - 1; i >= 0; i--) begin
      start = (i == W - 1);
      d_en  = 1'b1;
      d     = bits[i];
      if (i == 0 && ready_last) ready = 1'b1;
      tick();
      if (i == W - 1) chk({tag, "_busy_start"}, 32'(bm.busy), 32'h1);
      if (i == 1)     chk({tag, "_busy_mid"}, 32'(bl.busy), 32'h1);
    end
    start = 1'b0;
    d_en  = 1'b0;
    d     = 1'b0;
    ready = 1'b0;
    chk_done(tag, drop);
  endtask

  task automatic consume(input string tag);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'({bm.valid, bl.valid}), 32'h0);
  endtask

  initial begin
    logic [W-1:0] w;

    // Reset with every input active
    reset = 1'b1;
    d     = 1'b1;
    d_en  = 1'b1;
    start = 1'b1;
    ready = 1'b0;
    tick();
    chk_reset_state("rst1");
    tick();
    chk_reset_state("rst2");

    // Released: strobes without start, and ready with nothing valid, do nothing
    reset = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_no_start", 32'({bm.valid, bl.valid, bm.busy, bl.busy}), 32'h0);
    end
    ready = 1'b0;
    d_en  = 1'b0;
    d     = 1'b0;

    send_frame("a5", 8'hA5, 1'b0, 1'b0);
    consume("a5");
    send_frame("80", 8'h80, 1'b0, 1'b0);
    consume("80");

    // Consumer stalls: second word is dropped with a single overrun pulse
    send_frame("3c", 8'h3C, 1'b0, 1'b0);
    send_frame("ff_drop", 8'hFF, 1'b1, 1'b0);
    tick();
    chk("ovr_pulse_end", 32'({bm.overrun, bl.overrun}), 32'h0);
    chk("ovr_hold_data", 32'(bm.data_out), 32'h3C);
    chk("ovr_hold_valid", 32'(bm.valid), 32'h1);
    consume("3c");

    // Consume and complete on the same edge
    send_frame("12", 8'h12, 1'b0, 1'b0);
    send_frame("c3_swap", 8'hC3, 1'b0, 1'b1);
    consume("c3");

    // Three-bit partial frame, restart, then 5A with two-cycle d_en gaps
    start = 1'b1;
    d_en  = 1'b1;
    d     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    w = 8'h5A;
    q_msb.push_back(w);
    q_lsb.push_back(rev8(w));
    start = 1'b1;
    d     = w[W-1];
    tick();
    start = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      d_en = 1'b0;
      d    = 1'b1;
      tick();
      tick();
      if (i == 3) chk("gap_busy", 32'({bm.busy, bl.busy, bm.valid}), 32'h6);
      d_en = 1'b1;
      d    = w[i];
      tick();
    end
    d_en = 1'b0;
    d    = 1'b0;
    chk_done("5a_gap", 1'b0);

    // Reset mid-frame with 5A still pending
    start = 1'b1;
    d_en  = 1'b1;
    d     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    chk_reset_state("rst_mid");
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_rst_idle", 32'({bm.valid, bl.valid, bm.busy, bl.busy}), 32'h0);
    end
    d_en = 1'b0;
    send_frame("b1", 8'hB1, 1'b0, 1'b0);
    consume("b1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
